// File: rtl/game_pkg.sv
// Shared tic-tac-toe definitions: FSM state encoding, player codes and cell limits.
// Used by turn_scheduler and by the board controller.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_MOVE = 2'd1,
        ST_ISSUE     = 2'd2,
        ST_DONE      = 2'd3
    } state_e;

    localparam int          CELL_W   = 4;
    localparam logic [1:0]  P_NONE   = 2'd0;
    localparam logic [1:0]  P1       = 2'd1;
    localparam logic [1:0]  P2       = 2'd2;
    localparam logic [CELL_W-1:0] MAX_CELL = 4'd8;

    // Player who moves after p; anything that is not P1 hands over to P1.
    function automatic logic [1:0] other_player(input logic [1:0] p);
        return (p == P1) ? P2 : P1;
    endfunction

endpackage

// File: rtl/turn_timer.sv
// Per-turn up-counter: synchronous clear (dominant), hold (freeze) and an
// expire flag raised while the count sits at TURN_TIMEOUT-1.
module turn_timer
    import game_pkg::*;
#(
    parameter logic [31:0] TURN_TIMEOUT = 32'd500_000_000,
    parameter int          TMR_W        = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic hold,
    output logic expire
);

    logic [TMR_W-1:0] count_q;
    logic [TMR_W-1:0] count_d;

    // Next count: clear beats hold, otherwise count one per cycle.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (!hold) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = (count_q == TMR_W'(TURN_TIMEOUT - 32'd1));

endmodule

// File: rtl/turn_scheduler.sv
// turn_scheduler: grants the single move port to the player on turn, forwards
// one move per turn over valid/ready, auto-passes on timeout, halts on game_over.
// Optional macro ALT_FIRST_EN: first player alternates each game (P1, P2, ...);
// when undefined P1 always opens.
module turn_scheduler
    import game_pkg::*;
#(
    parameter logic [31:0] TURN_TIMEOUT = 32'd500_000_000,
    parameter int          TMR_W        = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              game_over,
    input  logic              p1_req,
    input  logic [CELL_W-1:0] p1_cell,
    output logic              p1_ack,
    input  logic              p2_req,
    input  logic [CELL_W-1:0] p2_cell,
    output logic              p2_ack,
    output logic              mv_valid,
    output logic [CELL_W-1:0] mv_cell,
    output logic [1:0]        mv_player,
    input  logic              mv_ready,
    input  logic              mv_ok,
    output logic [1:0]        turn,
    output logic              reject_pulse,
    output logic              timeout_pulse
);

    state_e            state_q, state_d;
    logic [1:0]        turn_q, turn_d;
    logic              mv_valid_q, mv_valid_d;
    logic [CELL_W-1:0] mv_cell_q, mv_cell_d;
    logic [1:0]        mv_player_q, mv_player_d;
    logic              p1_ack_q, p1_ack_d;
    logic              p2_ack_q, p2_ack_d;
    logic              reject_q, reject_d;
    logic              timeout_q, timeout_d;
    logic              tmr_clear, tmr_hold, tmr_expire;
    logic              sel_req, req_ok;
    logic [CELL_W-1:0] sel_cell;
    logic [1:0]        first_player;

`ifdef ALT_FIRST_EN
    logic [1:0] first_q, first_d;
    assign first_player = first_q;
`else
    assign first_player = P1;
`endif

    turn_timer #(
        .TURN_TIMEOUT (TURN_TIMEOUT),
        .TMR_W        (TMR_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (tmr_clear),
        .hold   (tmr_hold),
        .expire (tmr_expire)
    );

    // Only the on-turn player's request is looked at; off-turn requests are dropped.
    always_comb begin
        sel_req  = (turn_q == P1) ? p1_req  : p2_req;
        sel_cell = (turn_q == P1) ? p1_cell : p2_cell;
        req_ok   = (state_q == ST_WAIT_MOVE) && sel_req && (sel_cell <= MAX_CELL);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; game_over outranks every other event while playing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (start) state_d = ST_WAIT_MOVE;
            ST_DONE:      if (start && !game_over) state_d = ST_WAIT_MOVE;
            ST_WAIT_MOVE: begin
                if (game_over)   state_d = ST_DONE;
                else if (req_ok) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (game_over)     state_d = ST_DONE;
                else if (mv_ready) state_d = ST_WAIT_MOVE;
            end
            default:      state_d = ST_IDLE;
        endcase
    end

    // Output/datapath logic: turn, move payload, one-cycle pulses and timer control.
    always_comb begin
        turn_d      = turn_q;
        mv_valid_d  = mv_valid_q;
        mv_cell_d   = mv_cell_q;
        mv_player_d = mv_player_q;
        p1_ack_d    = 1'b0;
        p2_ack_d    = 1'b0;
        reject_d    = 1'b0;
        timeout_d   = 1'b0;
        tmr_clear   = 1'b0;
        tmr_hold    = 1'b0;
`ifdef ALT_FIRST_EN
        first_d     = first_q;
`endif
        case (state_q)
            ST_WAIT_MOVE: begin
                if (req_ok && !game_over) begin
                    // Timer is frozen from the accepting cycle so a rejected move resumes it intact.
                    tmr_hold    = 1'b1;
                    mv_valid_d  = 1'b1;
                    mv_cell_d   = sel_cell;
                    mv_player_d = turn_q;
                    p1_ack_d    = (turn_q == P1);
                    p2_ack_d    = (turn_q == P2);
                end else if (tmr_expire && !game_over) begin
                    turn_d    = other_player(turn_q);
                    tmr_clear = 1'b1;
                    timeout_d = 1'b1;
                end
            end
            ST_ISSUE: begin
                tmr_hold = 1'b1;
                if (mv_ready && !game_over) begin
                    mv_valid_d = 1'b0;
                    if (mv_ok) begin
                        turn_d    = other_player(turn_q);
                        tmr_clear = 1'b1;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            default: begin
                tmr_clear = 1'b1;
                if (state_d == ST_WAIT_MOVE) turn_d = first_player;
            end
        endcase
        // Entering DONE aborts any handshake in flight and suppresses all pulses.
        if (state_d == ST_DONE && state_q != ST_DONE) begin
            turn_d     = P_NONE;
            mv_valid_d = 1'b0;
            tmr_clear  = 1'b1;
`ifdef ALT_FIRST_EN
            first_d    = other_player(first_q);
`endif
        end
    end

    // Output and payload registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            turn_q      <= P_NONE;
            mv_valid_q  <= 1'b0;
            mv_cell_q   <= '0;
            mv_player_q <= P_NONE;
            p1_ack_q    <= 1'b0;
            p2_ack_q    <= 1'b0;
            reject_q    <= 1'b0;
            timeout_q   <= 1'b0;
`ifdef ALT_FIRST_EN
            first_q     <= P1;
`endif
        end else begin
            turn_q      <= turn_d;
            mv_valid_q  <= mv_valid_d;
            mv_cell_q   <= mv_cell_d;
            mv_player_q <= mv_player_d;
            p1_ack_q    <= p1_ack_d;
            p2_ack_q    <= p2_ack_d;
            reject_q    <= reject_d;
            timeout_q   <= timeout_d;
`ifdef ALT_FIRST_EN
            first_q     <= first_d;
`endif
        end
    end

    assign turn          = turn_q;
    assign mv_valid      = mv_valid_q;
    assign mv_cell       = mv_cell_q;
    assign mv_player     = mv_player_q;
    assign p1_ack        = p1_ack_q;
    assign p2_ack        = p2_ack_q;
    assign reject_pulse  = reject_q;
    assign timeout_pulse = timeout_q;

endmodule

// File: tb/tb_turn_scheduler.sv
// Bench for turn_scheduler (TURN_TIMEOUT=16): directed scenarios then random
// traffic, each cycle compared against a behavioural game model.
module tb_turn_scheduler;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       reset, start, game_over;
    logic       p1_req, p2_req, mv_ready, mv_ok;
    logic [3:0] p1_cell, p2_cell;
    logic       p1_ack, p2_ack, mv_valid, reject_pulse, timeout_pulse;
    logic [3:0] mv_cell;
    logic [1:0] mv_player, turn;

    int checks = 0;
    int errors = 0;

    // Model: phase 0 idle, 1 waiting for move, 2 move offered, 3 game done
    int m_phase = 0, m_turn = 0, m_waited = 0, m_first = 1, m_cell = 0, m_player = 0;
    bit m_valid = 0, m_ack1 = 0, m_ack2 = 0, m_rej = 0, m_to = 0;

    always #5 clk = ~clk;

    turn_scheduler #(
        .TURN_TIMEOUT (32'd16),
        .TMR_W        (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .game_over     (game_over),
        .p1_req        (p1_req),
        .p1_cell       (p1_cell),
        .p1_ack        (p1_ack),
        .p2_req        (p2_req),
        .p2_cell       (p2_cell),
        .p2_ack        (p2_ack),
        .mv_valid      (mv_valid),
        .mv_cell       (mv_cell),
        .mv_player     (mv_player),
        .mv_ready      (mv_ready),
        .mv_ok         (mv_ok),
        .turn          (turn),
        .reject_pulse  (reject_pulse),
        .timeout_pulse (timeout_pulse)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic game_ends();
        m_phase = 3; m_turn = 0; m_valid = 0; m_waited = 0;
`ifdef ALT_FIRST_EN
        m_first = 3 - m_first;
`endif
    endtask

    // Advance the game model by one clock using the inputs currently applied.
    task automatic model_step();
        int rq, c;
        m_ack1 = 0; m_ack2 = 0; m_rej = 0; m_to = 0;
        if (reset) begin
            m_phase = 0; m_turn = 0; m_waited = 0; m_first = 1;
            m_valid = 0; m_cell = 0; m_player = 0;
        end else if (m_phase == 0 || m_phase == 3) begin
            if (start && !(m_phase == 3 && game_over)) begin
                m_phase = 1; m_turn = m_first; m_waited = 0;
            end
        end else if (game_over) begin
            game_ends();
        end else if (m_phase == 1) begin
            rq = (m_turn == 1) ? int'(p1_req) : int'(p2_req);
            c  = (m_turn == 1) ? int'(p1_cell) : int'(p2_cell);
            if (rq == 1 && c <= 8) begin
                m_phase = 2; m_valid = 1; m_cell = c; m_player = m_turn;
                if (m_turn == 1) m_ack1 = 1; else m_ack2 = 1;
            end else if (m_waited == TO - 1) begin
                m_turn = 3 - m_turn; m_waited = 0; m_to = 1;
            end else begin
                m_waited++;
            end
        end else if (mv_ready) begin
            m_phase = 1; m_valid = 0;
            if (mv_ok) begin
                m_turn = 3 - m_turn; m_waited = 0;
            end else begin
                m_rej = 1;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("turn", turn, m_turn);
        check("mv_valid", mv_valid, m_valid);
        if (m_valid) begin
            check("mv_cell", mv_cell, m_cell);
            check("mv_player", mv_player, m_player);
        end
        check("p1_ack", p1_ack, m_ack1);
        check("p2_ack", p2_ack, m_ack2);
        check("reject_pulse", reject_pulse, m_rej);
        check("timeout_pulse", timeout_pulse, m_to);
        check("pulse_onehot", ($countones({p1_ack, p2_ack, reject_pulse, timeout_pulse}) <= 1), 1);
    endtask

    initial begin
        int found;
        int exp_first;
        reset = 1; start = 0; game_over = 0; p1_req = 0; p2_req = 0;
        p1_cell = 0; p2_cell = 0; mv_ready = 0; mv_ok = 0;
        tick(); tick();
        reset = 0;
        tick();

        // Start game, P1 plays cell 4, board stalls 5 cycles then accepts
        start = 1; tick(); start = 0;
        check("start_turn", turn, 1);
        p1_req = 1; p1_cell = 4'd4; tick(); p1_req = 0;
        check("t2_ack", p1_ack, 1);
        check("t2_cell", mv_cell, 4);
        repeat (5) tick();
        check("t2_cell_held", mv_cell, 4);
        mv_ready = 1; mv_ok = 1; tick(); mv_ready = 0;
        check("t2_turn", turn, 2);
        check("t2_timer", dut.u_timer.count_q, 0);

        // Reset while a move is being offered
        p2_req = 1; p2_cell = 4'd5; tick(); p2_req = 0;
        tick();
        check("t1_in_issue", mv_valid, 1);
        reset = 1; tick(); reset = 0;
        check("t1_state", dut.state_q, 0);
        check("t1_valid", mv_valid, 0);
        check("t1_turn", turn, 0);

        // Off-turn P2 request waits out a timeout, then is taken
        start = 1; tick(); start = 0;
        p2_req = 1; p2_cell = 4'd3;
        found = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (timeout_pulse === 1'b1) begin
                found = i;
                break;
            end
        end
        check("t3_timeout_cycle", found, TO);
        check("t3_turn", turn, 2);
        tick(); p2_req = 0;
        check("t3_p2_ack", p2_ack, 1);

        // Board rejects, P2 retries cell 0 and is rejected again, then succeeds
        mv_ready = 1; mv_ok = 0; tick(); mv_ready = 0;
        p2_req = 1; p2_cell = 4'd0; tick(); p2_req = 0;
        mv_ready = 1; mv_ok = 0; tick(); mv_ready = 0;
        check("t4_reject", reject_pulse, 1);
        check("t4_turn", turn, 2);
        p2_req = 1; p2_cell = 4'd7; tick(); p2_req = 0;
        mv_ready = 1; mv_ok = 1; tick(); mv_ready = 0;
        check("t4_turn_p1", turn, 1);
        p1_req = 1; p1_cell = 4'd9;
        repeat (3) tick();
        check("t4_bad_cell_ack", p1_ack, 0);
        p1_req = 0;

        // Request lands on the expiry cycle; then game_over mid-handshake
        reset = 1; tick(); reset = 0;
        start = 1; tick(); start = 0;
        repeat (TO - 1) tick();
        p1_req = 1; p1_cell = 4'd2; tick(); p1_req = 0;
        check("t5_ack", p1_ack, 1);
        check("t5_no_timeout", timeout_pulse, 0);
        tick();
        game_over = 1; tick();
        check("t5_abort_valid", mv_valid, 0);
        check("t5_done_state", dut.state_q, 3);
        start = 1; tick(); start = 0;
        check("t5_stay_done", turn, 0);
        game_over = 0; tick();

        // First player over three games
        reset = 1; tick(); reset = 0;
        for (int g = 0; g < 3; g++) begin
            start = 1; tick(); start = 0;
`ifdef ALT_FIRST_EN
            exp_first = (g % 2 == 0) ? 1 : 2;
`else
            exp_first = 1;
`endif
            check("t6_first", turn, exp_first);
            game_over = 1; tick(); game_over = 0; tick();
        end

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            reset     = ($urandom_range(0, 199) == 0);
            start     = ($urandom_range(0, 15) == 0);
            game_over = ($urandom_range(0, 39) == 0);
            p1_req    = ($urandom_range(0, 2) == 0);
            p2_req    = ($urandom_range(0, 2) == 0);
            p1_cell   = 4'($urandom_range(0, 10));
            p2_cell   = 4'($urandom_range(0, 10));
            mv_ready  = ($urandom_range(0, 1) == 0);
            mv_ok     = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
